// File: rtl/osc_mode_sequencer.sv
// Schedules the 2-bit mode oscillator through ROUNDS x (DWELL0 @ A=0, DWELL1 @ A=1)
// and checks every oscillator step against the expected next state.
module osc_mode_sequencer #(
  parameter int DW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dwell0,
  input  logic [DW-1:0] dwell1,
  input  logic [RW-1:0] rounds,
  input  logic [1:0]    osc_state,
  output logic          osc_a,
  output logic          osc_clr,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] round_cnt,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, CLR, PH0, PH1, DONE} state_t;

  state_t        st, st_nx;
  logic [DW-1:0] d0_q, d1_q, dcnt, lim0, lim1;
  logic [RW-1:0] rnd_q, rcnt, rcnt_inc;
  logic          err_q, chk_fail, ph_end0, ph_end1, phase;
  logic [1:0]    prev_state;
  logic          prev_a, prev_valid, first_ph0;

  // A dwell of 0 behaves as 1, so the terminal count saturates at 0
  assign lim0     = (d0_q == '0) ? '0 : d0_q - DW'(1);
  assign lim1     = (d1_q == '0) ? '0 : d1_q - DW'(1);
  assign ph_end0  = (dcnt == lim0);
  assign ph_end1  = (dcnt == lim1);
  assign rcnt_inc = rcnt + RW'(1);
  assign phase    = (st == PH0) || (st == PH1);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (start) st_nx = (rounds == '0) ? DONE : CLR;
      CLR:  st_nx = abort ? IDLE : PH0;
      PH0:  if (abort) st_nx = IDLE;
            else if (ph_end0) st_nx = PH1;
      PH1:  if (abort) st_nx = IDLE;
            else if (ph_end1) st_nx = (rcnt_inc == rnd_q) ? DONE : PH0;
      DONE: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // First PH0 after CLR must see a cleared oscillator; afterwards each step
  // must toggle exactly the bit selected by the previous A.
  always_comb begin
    chk_fail = 1'b0;
    if (phase) begin
      if (first_ph0)
        chk_fail = (osc_state != 2'b00);
      else if (prev_valid)
        chk_fail = (osc_state != (prev_state ^ (prev_a ? 2'b10 : 2'b01)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      d0_q       <= '0;
      d1_q       <= '0;
      rnd_q      <= '0;
      dcnt       <= '0;
      rcnt       <= '0;
      err_q      <= 1'b0;
      prev_state <= 2'b00;
      prev_a     <= 1'b0;
      prev_valid <= 1'b0;
      first_ph0  <= 1'b0;
    end else begin
      st         <= st_nx;
      prev_state <= osc_state;
      prev_a     <= osc_a;
      prev_valid <= phase;
      first_ph0  <= (st == CLR);
      if (chk_fail) err_q <= 1'b1;
      unique case (st)
        IDLE: if (start) begin
          d0_q  <= dwell0;
          d1_q  <= dwell1;
          rnd_q <= rounds;
          dcnt  <= '0;
          rcnt  <= '0;
          err_q <= 1'b0;
        end
        PH0: if (!abort) dcnt <= ph_end0 ? '0 : dcnt + DW'(1);
        PH1: if (!abort) begin
          if (ph_end1) begin
            dcnt <= '0;
            rcnt <= rcnt_inc;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign osc_a     = (st == PH1);
  assign osc_clr   = (st == CLR);
  assign busy      = (st == CLR) || phase;
  assign done      = (st == DONE);
  assign round_cnt = rcnt;
  assign err       = err_q;

endmodule

// File: tb/tb_osc_mode_sequencer.sv
// Directed bench: per-cycle vector table for full runs plus hand sequences
// for abort, checker error, start-while-busy and asynchronous reset.
module tb_osc_mode_sequencer;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] dwell0 = '0, dwell1 = '0;
  logic [3:0] rounds = '0, round_cnt;
  logic [1:0] osc_state, osc_ref;
  logic       osc_a, osc_clr, busy, done, err, hold = 1'b0;

  int n_chk = 0, n_fail = 0;

  osc_mode_sequencer #(.DW(8), .RW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dwell0(dwell0), .dwell1(dwell1), .rounds(rounds),
    .osc_state(osc_state), .osc_a(osc_a), .osc_clr(osc_clr),
    .busy(busy), .done(done), .round_cnt(round_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference oscillator: clear, else toggle bit selected by A
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          osc_ref <= 2'b00;
    else if (osc_clr) osc_ref <= 2'b00;
    else              osc_ref <= osc_ref ^ (osc_a ? 2'b10 : 2'b01);
  end
  assign osc_state = hold ? 2'b01 : osc_ref;

  typedef struct {
    logic       st;
    logic [7:0] d0, d1;
    logic [3:0] rn;
    logic [3:0] exp;  // {osc_clr, osc_a, busy, done}
    logic [3:0] rc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] r, input logic [3:0] e, input logic [3:0] c);
    vec_t v;
    v.st = s; v.d0 = a; v.d1 = b; v.rn = r; v.exp = e; v.rc = c;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] outs();
    return {osc_clr, osc_a, busy, done};
  endfunction

  initial begin
    // run 1: 2/3/2, start again in DONE must be ignored
    add(1, 2, 3, 2, 4'b0000, 0);
    add(0, 2, 3, 2, 4'b1010, 0);
    add(0, 2, 3, 2, 4'b0010, 0); add(0, 2, 3, 2, 4'b0010, 0);
    add(0, 2, 3, 2, 4'b0110, 0); add(0, 2, 3, 2, 4'b0110, 0); add(0, 2, 3, 2, 4'b0110, 0);
    add(0, 2, 3, 2, 4'b0010, 1); add(0, 2, 3, 2, 4'b0010, 1);
    add(0, 2, 3, 2, 4'b0110, 1); add(0, 2, 3, 2, 4'b0110, 1); add(0, 2, 3, 2, 4'b0110, 1);
    add(1, 2, 3, 2, 4'b0001, 2);
    add(0, 2, 3, 2, 4'b0000, 2);
    // run 2: zero dwells, 3 rounds alternate every cycle
    add(1, 0, 0, 3, 4'b0000, 2);
    add(0, 0, 0, 3, 4'b1010, 0);
    add(0, 0, 0, 3, 4'b0010, 0); add(0, 0, 0, 3, 4'b0110, 0);
    add(0, 0, 0, 3, 4'b0010, 1); add(0, 0, 0, 3, 4'b0110, 1);
    add(0, 0, 0, 3, 4'b0010, 2); add(0, 0, 0, 3, 4'b0110, 2);
    add(0, 0, 0, 3, 4'b0001, 3);
    add(0, 0, 0, 3, 4'b0000, 3);
    // run 3: rounds=0 goes straight to DONE
    add(1, 5, 5, 0, 4'b0000, 3);
    add(0, 5, 5, 0, 4'b0001, 0);
    add(0, 5, 5, 0, 4'b0000, 0);

    // reset state, sampled while rst is held
    #2;
    chk("rst_outs", 8'(outs()), 8'h0);
    chk("rst_rc",   8'(round_cnt), 8'h0);
    chk("rst_err",  8'(err), 8'h0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    foreach (tv[i]) begin
      start = tv[i].st; dwell0 = tv[i].d0; dwell1 = tv[i].d1; rounds = tv[i].rn;
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 8'(outs()), 8'(tv[i].exp));
      chk($sformatf("vec%0d_rc", i), 8'(round_cnt), 8'(tv[i].rc));
      chk($sformatf("vec%0d_err", i), 8'(err), 8'h0);
      cyc();
    end
    start = 1'b0;

    // abort in second PH1 cycle of round index 1, then restart
    start = 1; dwell0 = 4; dwell1 = 4; rounds = 5;
    cyc(); start = 0;
    repeat (14) cyc();
    @(negedge clk);
    chk("abort_pre_outs", 8'(outs()), 8'b0110);
    chk("abort_pre_rc", 8'(round_cnt), 8'h1);
    abort = 1; cyc(); abort = 0;
    @(negedge clk);
    chk("abort_idle_outs", 8'(outs()), 8'b0000);
    chk("abort_idle_rc", 8'(round_cnt), 8'h1);
    abort = 1; cyc(); abort = 0;
    @(negedge clk);
    chk("abort_in_idle", 8'(outs()), 8'b0000);
    cyc();
    start = 1; dwell0 = 1; dwell1 = 1; rounds = 1;
    cyc(); start = 0;
    @(negedge clk); chk("restart_clr", 8'(outs()), 8'b1010);
    cyc(); @(negedge clk); chk("restart_ph0", 8'(outs()), 8'b0010);
    cyc(); @(negedge clk); chk("restart_ph1", 8'(outs()), 8'b0110);
    cyc(); @(negedge clk); chk("restart_done", 8'(outs()), 8'b0001);
    chk("restart_rc", 8'(round_cnt), 8'h1);
    cyc();

    // forced oscillator from cycle 4 -> err at cycle 5, sticky to DONE
    start = 1; dwell0 = 2; dwell1 = 3; rounds = 2;
    cyc(); start = 0;
    cyc(); cyc();
    @(negedge clk); chk("err_c3", 8'(err), 8'h0);
    cyc(); hold = 1;
    @(negedge clk); chk("err_c4", 8'(err), 8'h0);
    cyc(); @(negedge clk); chk("err_c5", 8'(err), 8'h1);
    repeat (7) cyc();
    @(negedge clk);
    chk("err_done_outs", 8'(outs()), 8'b0001);
    chk("err_done", 8'(err), 8'h1);
    hold = 0;
    cyc(); @(negedge clk); chk("err_idle", 8'(err), 8'h1);
    start = 1; rounds = 0;
    cyc(); start = 0;
    @(negedge clk); chk("err_cleared", 8'(err), 8'h0);
    chk("err_clr_done", 8'(outs()), 8'b0001);
    cyc();

    // start while busy ignored; async reset mid-PH1
    start = 1; dwell0 = 2; dwell1 = 3; rounds = 2;
    cyc(); start = 0;
    cyc(); cyc(); cyc(); hold = 1;
    cyc(); cyc(); cyc();
    start = 1; cyc(); start = 0;
    @(negedge clk); chk("busy_start_c8", 8'(outs()), 8'b0010);
    cyc(); @(negedge clk);
    chk("busy_start_c9", 8'(outs()), 8'b0110);
    chk("pre_rst_rc", 8'(round_cnt), 8'h1);
    chk("pre_rst_err", 8'(err), 8'h1);
    #1 rst = 1; #1;
    chk("async_rst_outs", 8'(outs()), 8'h0);
    chk("async_rst_rc", 8'(round_cnt), 8'h0);
    chk("async_rst_err", 8'(err), 8'h0);
    hold = 0;
    cyc(); rst = 0;
    @(negedge clk); chk("post_rst_outs", 8'(outs()), 8'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
